// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline-facing request/response bus plus the data-memory port of the load/store controller.
// The master side is whatever drives requests and models the memory; the controller is the slave.
interface lsu_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_wen;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_raddr, mem_waddr, mem_wdata, mem_wen
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_raddr, mem_waddr, mem_wdata, mem_wen
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-addressed memory with a 1-cycle registered read port.
// Sub-word stores are merged by read-modify-write; loads return sign/zero-extended lane data.
module lsu_mem_ctrl #(
   parameter bit ALIGN_CHECK = 1'b1,
   parameter bit RMW_SUBWORD = 1'b1
) (
   input logic           clk,
   input logic           rst,
   lsu_mem_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LD_ADDR, LD_DATA, ST_WR, RMW_RD, RMW_WR, RESP} state_e;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL} size_e;

   state_e      state_q, state_d;
   size_e       size_q, size_d;
   logic        signed_q, signed_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   size_e       req_size;
   logic        misaligned;
   logic        req_bad;
   logic [4:0]  lane_sh;
   logic [15:0] ld_lane;
   logic [31:0] ld_ext;
   logic [31:0] lane_mask;
   logic [31:0] merged;

   always_comb begin
      req_size   = size_e'(bus.req_size);
      misaligned = (req_size == SZ_HALF && bus.req_addr[0]) ||
                   (req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);
      req_bad    = (req_size == SZ_ILL) || (ALIGN_CHECK && misaligned) ||
                   (!RMW_SUBWORD && bus.req_we && req_size != SZ_WORD);
   end

   // Lane datapath: load extraction in LD_DATA, store merge in RMW_WR, both off the live read data.
   always_comb begin
      lane_sh = {off_q, 3'b000};
      ld_lane = 16'(bus.mem_rdata >> lane_sh);
      unique case (size_q)
         SZ_BYTE: ld_ext = {{24{signed_q & ld_lane[7]}}, ld_lane[7:0]};
         SZ_HALF: ld_ext = {{16{signed_q & ld_lane[15]}}, ld_lane};
         default: ld_ext = bus.mem_rdata;
      endcase
      lane_mask = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
      merged    = (bus.mem_rdata & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
   end

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the case infers a latch.
      state_d  = state_q;
      size_d   = size_q;
      signed_d = signed_q;
      off_d    = off_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               size_d   = req_size;
               signed_d = bus.req_signed;
               wdata_d  = bus.req_wdata;
               waddr_d  = {2'b00, bus.req_addr[31:2]};
               // Forcing the lane offset aligned is harmless when misalignment is an error anyway.
               off_d    = (req_size == SZ_WORD) ? 2'b00 :
                          (req_size == SZ_HALF) ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0];
               err_d    = req_bad;
               if (req_bad)                  state_d = RESP;
               else if (!bus.req_we)         state_d = LD_ADDR;
               else if (req_size == SZ_WORD) state_d = ST_WR;
               else                          state_d = RMW_RD;
            end
         end
         LD_ADDR: state_d = LD_DATA;
         LD_DATA: begin
            rdata_d = ld_ext;
            state_d = RESP;
         end
         ST_WR:   state_d = RESP;
         RMW_RD:  state_d = RMW_WR;
         RMW_WR:  state_d = RESP;
         RESP: begin
            rdata_d = 32'h0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = (state_q == IDLE) && !rst;
      bus.resp_valid = (state_q == RESP);
      bus.resp_err   = err_q;
      bus.resp_rdata = rdata_q;
      bus.mem_raddr  = waddr_q;
      bus.mem_waddr  = waddr_q;
      bus.mem_wen    = ((state_q == ST_WR) || (state_q == RMW_WR)) && !rst;
      bus.mem_wdata  = 32'h0;
      if (state_q == ST_WR)       bus.mem_wdata = wdata_q;
      else if (state_q == RMW_WR) bus.mem_wdata = merged;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         size_q   <= SZ_BYTE;
         signed_q <= 1'b0;
         off_q    <= 2'b00;
         waddr_q  <= 32'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         off_q    <= off_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

endmodule
